uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default baud divisor.
// The receiver uses the same package, so the encoding must stay stable.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle of
// each serial bit. Holding clear keeps the count at zero, so the first
// bit after clear is released is full length.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: cleared on request, wraps after the last cycle of a bit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, no parity, 1 or 2 stop bits, LSB first.
// A one-byte holding register sits in front of the shift register so the
// next byte can be queued while a frame is on the line; frames then run
// back-to-back. All line-side outputs are registered, so txd and tx_done
// trail the FSM state by one cycle.
//
// Handshake: a byte is taken on a rising edge where tx_valid and tx_ready
// are both 1; tx_ready is simply "holding register empty" and offers made
// while it is 0 are dropped without any indication.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        txd,
  output logic        tx_busy,
  output logic        tx_done,
  output uart_state_e dbg_state
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;
  logic        bit_end;
  logic        accept;
  logic        load;

  assign accept = tx_valid && !hold_full_q;

  // Baud timer runs only while a frame is in progress.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  // Next-state, shift/holding updates and registered line outputs.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP) begin
            done_d    = 1'b1;
            bit_cnt_d = 3'd0;
            if (hold_full_q) begin
              state_d = ST_START;
              load    = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load and accept never coincide: load needs holding full, accept empty.
    if (load) begin
      shift_d     = hold_q;
      hold_d      = 8'h00;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      txd_q       <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      txd_q       <= txd_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready  = !hold_full_q;
  assign txd       = txd_q;
  assign tx_busy   = (state_q != ST_IDLE);
  assign tx_done   = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: instance A uses defaults (16 clk/bit, 1 stop bit),
// instance B uses 4 clk/bit with 2 stop bits. Drivers push accepted bytes
// into per-instance expected queues; monitors decode the serial line from
// the framing rules and compare every frame against the queue head.
module tb_uart_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0]  data_a = 8'h00, data_b = 8'h00;
  logic        ready_a, txd_a, busy_a, done_a;
  logic        ready_b, txd_b, busy_b, done_b;
  uart_state_e st_a, st_b;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  int unsigned starts_a[$];
  int          frames_b = 0;
  int unsigned acc_edge = 0;

  uart_tx u_dut_a (
    .clk(clk), .n_rst(n_rst), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .txd(txd_a), .tx_busy(busy_a), .tx_done(done_a),
    .dbg_state(st_a)
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .txd(txd_b), .tx_busy(busy_b), .tx_done(done_b),
    .dbg_state(st_b)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  function automatic logic line_of(input bit w);
    return w ? txd_b : txd_a;
  endfunction

  function automatic logic done_of(input bit w);
    return w ? done_b : done_a;
  endfunction

  function automatic logic busy_of(input bit w);
    return w ? busy_b : busy_a;
  endfunction

  function automatic int qsize(input bit w);
    return w ? exp_b.size() : exp_a.size();
  endfunction

  // One-cycle offer; the byte is expected on the line only if accepted.
  task automatic offer(input bit w, input logic [7:0] b, output bit acc);
    @(negedge clk);
    acc = w ? ready_b : ready_a;
    if (w) begin valid_b = 1'b1; data_b = b; end
    else   begin valid_a = 1'b1; data_a = b; end
    if (acc) begin
      if (w) exp_b.push_back(b); else exp_a.push_back(b);
      acc_edge = cyc + 1;
    end
    @(negedge clk);
    // Scramble data after the handshake; the frame must not follow it.
    if (w) begin valid_b = 1'b0; data_b = 8'($urandom); end
    else   begin valid_a = 1'b0; data_a = 8'($urandom); end
  endtask

  task automatic send(input bit w, input logic [7:0] b);
    int n = 0;
    bit acc;
    while (!(w ? ready_b : ready_a) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait_in_budget", int'(n < 2000), 1);
    offer(w, b, acc);
    chk("send_accepted", int'(acc), 1);
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (starts_a.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen_in_budget", int'(t < 3000), 1);
  endtask

  task automatic wait_idle(input bit w);
    int n = 0;
    while (n < 6000 && !(qsize(w) == 0 && !busy_of(w) && line_of(w))) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget", int'(n < 6000), 1);
    repeat (4) @(negedge clk);
  endtask

  // Line monitor: decodes frames from txd using the framing rules alone.
  task automatic monitor(input bit w);
    int cpb, len, bw, bd, bb, qs;
    logic [7:0] e, got;
    logic exp_lvl;
    bit ab;
    cpb = w ? 4 : 16;
    len = (w ? 11 : 10) * cpb;
    forever begin
      @(negedge clk);
      if (!n_rst) continue;
      if (line_of(w)) begin
        chk(w ? "b_idle_done" : "a_idle_done", int'(done_of(w)), 0);
        continue;
      end
      if (!w) starts_a.push_back(cyc);
      qs = qsize(w);
      chk(w ? "b_frame_expected" : "a_frame_expected", int'(qs > 0), 1);
      e = 8'h00;
      if (qs > 0) e = w ? exp_b.pop_front() : exp_a.pop_front();
      bw = 0; bd = 0; bb = 0; got = 8'h00; ab = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (k > 0) @(negedge clk);
        if (!n_rst) begin ab = 1'b1; break; end
        if (k < cpb)          exp_lvl = 1'b0;
        else if (k < 9 * cpb) exp_lvl = e[k / cpb - 1];
        else                  exp_lvl = 1'b1;
        if (line_of(w) != exp_lvl) bw++;
        if (done_of(w) != (k == len - 1)) bd++;
        if (k < len - 1 && !busy_of(w)) bb++;
        if (k >= cpb && k < 9 * cpb && (k % cpb) == cpb / 2) got[k / cpb - 1] = line_of(w);
      end
      if (!ab) begin
        chk(w ? "b_byte" : "a_byte", int'(got), int'(e));
        chk(w ? "b_wave_errs" : "a_wave_errs", bw, 0);
        chk(w ? "b_done_errs" : "a_done_errs", bd, 0);
        chk(w ? "b_busy_errs" : "a_busy_errs", bb, 0);
        if (w) frames_b++;
      end
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #600000;
    chk("watchdog_not_expired", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Main sequence.
  initial begin
    bit acc;
    int nbad, n0;
    int unsigned s1;
    fork
      monitor(1'b0);
      monitor(1'b1);
    join_none

    repeat (3) @(negedge clk);
    chk("reset_txd", int'(txd_a), 1);
    chk("reset_ready", int'(ready_a), 1);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_state", int'(st_a), 0);
    chk("reset_state_b", int'(st_b), 0);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_frame_without_byte", starts_a.size(), 0);

    // 0x55 into an idle block: check handshake and start latency.
    send(1'b0, 8'h55);
    chk("ready_low_after_accept", int'(ready_a), 0);
    @(negedge clk);
    chk("ready_after_load", int'(ready_a), 1);
    chk("busy_after_load", int'(busy_a), 1);
    chk("txd_high_before_start", int'(txd_a), 1);
    wait_starts(1);
    chk("start_latency", int'(starts_a[0] - acc_edge), 2);
    wait_idle(1'b0);

    // 0xA3 then 0x0F while busy; third byte ignored; back-to-back frames.
    send(1'b0, 8'hA3);
    wait_starts(2);
    s1 = starts_a[1];
    repeat ($urandom_range(5, 60)) @(negedge clk);
    offer(1'b0, 8'h0F, acc);
    chk("second_accepted", int'(acc), 1);
    offer(1'b0, 8'h77, acc);
    chk("third_ignored", int'(acc), 0);
    nbad = 0;
    while (cyc < s1 + 159) begin
      if (ready_a) nbad++;
      valid_a = 1'b1;
      data_a = 8'h77;
      @(negedge clk);
    end
    valid_a = 1'b0;
    chk("ready_low_while_holding", nbad, 0);
    chk("ready_at_frame_end", int'(ready_a), 1);
    wait_starts(3);
    chk("back_to_back_spacing", int'(starts_a[2] - s1), 160);
    wait_idle(1'b0);

    // Byte patterns checked by the line decoder.
    send(1'b0, 8'h00);
    send(1'b0, 8'hFF);
    send(1'b0, 8'h81);
    wait_idle(1'b0);

    // Reset during DATA of 0xC4 with a byte waiting in holding.
    n0 = starts_a.size();
    send(1'b0, 8'hC4);
    wait_starts(n0 + 1);
    repeat (48) @(negedge clk);
    offer(1'b0, 8'h99, acc);
    chk("in_data_state", int'(st_a), 2);
    #3 n_rst = 1'b0;
    #1;
    chk("abort_txd", int'(txd_a), 1);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_ready", int'(ready_a), 1);
    chk("abort_done", int'(done_a), 0);
    exp_a.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_frame_after_abort", starts_a.size(), n0 + 1);
    send(1'b0, 8'h12);
    wait_idle(1'b0);

    // Random bytes, gaps and extra offers.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 120)) @(negedge clk);
      send(1'b0, 8'($urandom));
      if ($urandom_range(0, 1) == 1) offer(1'b0, 8'($urandom), acc);
    end
    wait_idle(1'b0);

    // Two stop bits at 4 clk/bit: 44-cycle frames.
    send(1'b1, 8'h01);
    send(1'b1, 8'($urandom));
    send(1'b1, 8'($urandom));
    wait_idle(1'b1);
    chk("frames_b", frames_b, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
